// File: rtl/conv_result_streamer.sv
// Result streamer for a convolution engine: buffers raster-order words and tags row/frame ends.
// Latency: one cycle from a push into an empty FIFO to out_valid.
// Backpressure: out_ready stalls the FIFO head; in_ready drops when the FIFO is full or the frame is complete.

// Generic synchronous FIFO with flush; head word read combinationally from storage.
// Latency: one cycle from write to visibility at the head.
// Backpressure: writes refused while full (even with a same-cycle read); reads ignored while empty.
module conv_result_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             wr_vld,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic             rd_rdy,
  output logic [WIDTH-1:0] rd_dat,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             wr_en;
  logic             rd_en;

  assign full   = (count == FULL_CNT);
  assign empty  = (count == '0);
  assign wr_en  = wr_vld && !full && !flush;
  assign rd_en  = rd_rdy && !empty && !flush;
  assign rd_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      if (wr_en && !rd_en)
        count <= count + (AW+1)'(1);
      else if (rd_en && !wr_en)
        count <= count - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_dat;
  end
endmodule

// Frame controller: accepts a frame start, streams D*D result words with row/frame end markers.
// Latency: one cycle in-to-out through the FIFO; done pulses the cycle after the last word leaves.
// Backpressure: out_ready stalls the stream; in_valid against a full FIFO mid-frame aborts with overflow.
module conv_result_streamer #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  input_size,
  input  logic [7:0]  filter_size,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready,
  output logic        out_last_col,
  output logic        out_last,
  output logic        busy,
  output logic        done,
  output logic        size_err,
  output logic        overflow
);
  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  // Frame geometry kept as last index (D-1) and total word count (D*D).
  typedef struct packed {
    logic [7:0]  dm1;
    logic [15:0] len;
  } cfg_t;

  state_t      state_q;
  state_t      state_d;
  cfg_t        cfg_q;
  logic [15:0] rcv_cnt;
  logic [7:0]  col;
  logic [7:0]  row;
  logic [15:0] d_wide;
  logic        fifo_empty;
  logic        fifo_full;
  logic        fifo_flush;
  logic        start_acc;
  logic        sizes_ok;
  logic        all_rcvd;
  logic        push;
  logic        pop;
  logic        ovf_hit;
  logic        col_end;
  logic        last_pop;

  assign start_acc  = (state_q == IDLE) && start;
  assign sizes_ok   = (filter_size != 8'd0) && (filter_size <= 8'd16) && (filter_size <= input_size);
  assign d_wide     = {8'd0, input_size - filter_size + 8'd1};
  assign all_rcvd   = (rcv_cnt == cfg_q.len);
  assign push       = in_valid && in_ready;
  assign pop        = out_valid && out_ready;
  assign col_end    = (col == cfg_q.dm1);
  assign last_pop   = pop && col_end && (row == cfg_q.dm1);
  // A word offered against a full FIFO before the frame is complete cannot be held: abort.
  assign ovf_hit    = (state_q == STREAM) && in_valid && fifo_full && !all_rcvd;
  assign fifo_flush = start_acc || ovf_hit;

  conv_result_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .flush  (fifo_flush),
    .wr_vld (push),
    .wr_dat (in_data),
    .rd_rdy (pop),
    .rd_dat (out_data),
    .empty  (fifo_empty),
    .full   (fifo_full)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && sizes_ok) state_d = STREAM;
      STREAM:  if (ovf_hit)           state_d = IDLE;
               else if (last_pop)     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy         = (state_q == STREAM);
    done         = (state_q == DONE);
    in_ready     = busy && !fifo_full && !all_rcvd;
    out_valid    = busy && !fifo_empty;
    out_last_col = out_valid && col_end;
    out_last     = out_last_col && (row == cfg_q.dm1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_q    <= '0;
      rcv_cnt  <= '0;
      col      <= '0;
      row      <= '0;
      size_err <= 1'b0;
      overflow <= 1'b0;
    end else if (start_acc) begin
      cfg_q.dm1 <= input_size - filter_size;
      cfg_q.len <= d_wide * d_wide;
      rcv_cnt   <= '0;
      col       <= '0;
      row       <= '0;
      size_err  <= !sizes_ok;
      overflow  <= 1'b0;
    end else begin
      if (ovf_hit) overflow <= 1'b1;
      if (push)    rcv_cnt  <= rcv_cnt + 16'd1;
      if (pop) begin
        if (col_end) begin
          col <= '0;
          row <= row + 8'd1;
        end else begin
          col <= col + 8'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_conv_result_streamer.sv
// Directed bench for conv_result_streamer: hand-computed frame geometries, stalls, overflow, size errors, reset.
module tb_conv_result_streamer;
  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  input_size;
  logic [7:0]  filter_size;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic        out_last_col;
  logic        out_last;
  logic        busy;
  logic        done;
  logic        size_err;
  logic        overflow;

  int checks   = 0;
  int failures = 0;
  logic [31:0] vec [0:63];

  conv_result_streamer #(.FIFO_DEPTH(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .input_size   (input_size),
    .filter_size  (filter_size),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .out_last_col (out_last_col),
    .out_last     (out_last),
    .busy         (busy),
    .done         (done),
    .size_err     (size_err),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got=running exp=finished");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Called at a negedge; start is held across exactly one rising edge.
  task automatic do_start(input logic [7:0] n, input logic [7:0] f);
    start       = 1'b1;
    input_size  = n;
    filter_size = f;
    @(negedge clk);
    start = 1'b0;
    #1;
  endtask

  // Drives vec[] in and checks it comes out in order with row/frame markers for edge d.
  task automatic stream_frame(input string tag, input int d, input int total, input int hold,
                              input int hold_fill, input bit extra_valid, input int abort_after);
    int sent, rcvd, cyc, first_push, first_ov;
    logic [31:0] prev_dat;
    logic prev_last, prev_stall;
    sent = 0; rcvd = 0; cyc = 0; first_push = -1; first_ov = -1;
    prev_dat = '0; prev_last = 1'b0; prev_stall = 1'b0;
    @(negedge clk);
    while (rcvd < total && rcvd != abort_after && cyc < 2000) begin
      in_valid  = (sent < total) || extra_valid;
      in_data   = (sent < total) ? vec[sent] : 32'hDEAD_BEEF;
      out_ready = (cyc >= hold);
      #1;
      if (hold > 0 && cyc == hold) begin
        check_eq({tag, "_sent_at_release"}, sent, hold_fill);
        check_eq({tag, "_in_ready_stalled"}, 32'(in_ready), 32'd0);
        check_eq({tag, "_no_overflow_stalled"}, 32'(overflow), 32'd0);
        check_eq({tag, "_out_valid_stalled"}, 32'(out_valid), 32'd1);
      end
      if (prev_stall) begin
        check_eq({tag, "_hold_data"}, out_data, prev_dat);
        check_eq({tag, "_hold_last"}, 32'(out_last), 32'(prev_last));
      end
      check_eq({tag, "_done_early"}, 32'(done), 32'd0);
      if (out_valid && first_ov < 0) first_ov = cyc;
      if (in_valid && in_ready) begin
        if (first_push < 0) first_push = cyc;
        sent++;
      end
      if (out_valid && out_ready) begin
        check_eq({tag, "_data"}, out_data, vec[rcvd]);
        check_eq({tag, "_last_col"}, 32'(out_last_col), 32'((rcvd % d) == d - 1));
        check_eq({tag, "_last"}, 32'(out_last), 32'(rcvd == total - 1));
        rcvd++;
      end
      prev_stall = out_valid && !out_ready;
      prev_dat   = out_data;
      prev_last  = out_last;
      @(negedge clk);
      cyc++;
    end
    if (abort_after < 0) begin
      check_eq({tag, "_words_delivered"}, rcvd, total);
      check_eq({tag, "_in_to_out_latency"}, first_ov - first_push, 32'd1);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      #1;
      check_eq({tag, "_done_pulse"}, 32'(done), 32'd1);
      check_eq({tag, "_busy_in_done"}, 32'(busy), 32'd0);
      @(negedge clk);
      #1;
      check_eq({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    end else begin
      check_eq({tag, "_words_before_abort"}, rcvd, abort_after);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check_eq({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check_eq({tag, "_out_last_col"}, 32'(out_last_col), 32'd0);
    check_eq({tag, "_out_last"}, 32'(out_last), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_done"}, 32'(done), 32'd0);
    check_eq({tag, "_size_err"}, 32'(size_err), 32'd0);
    check_eq({tag, "_overflow"}, 32'(overflow), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; input_size = 8'd0; filter_size = 8'd0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_outputs("por");

    // N=4,F=3 -> D=2, four float words 1.0..4.0.
    vec[0] = 32'h3F80_0000; vec[1] = 32'h4000_0000;
    vec[2] = 32'h4040_0000; vec[3] = 32'h4080_0000;
    do_start(8'd4, 8'd3);
    check_eq("t1_busy", 32'(busy), 32'd1);
    check_eq("t1_in_ready", 32'(in_ready), 32'd1);
    check_eq("t1_out_valid_empty", 32'(out_valid), 32'd0);
    stream_frame("t1", 2, 4, 0, 0, 1'b0, -1);

    // N=5,F=2 -> D=4, 16 words fill the FIFO exactly under a 20-cycle stall.
    for (int i = 0; i < 16; i++) vec[i] = 32'h1000_0000 + 32'(i * 3);
    do_start(8'd5, 8'd2);
    stream_frame("t2", 4, 16, 20, 16, 1'b1, -1);
    check_eq("t2_no_overflow", 32'(overflow), 32'd0);

    // N=10,F=1 -> D=10; 17th word against a full FIFO aborts the frame.
    do_start(8'd10, 8'd1);
    out_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1;
      in_data  = 32'(i);
      #1;
      check_eq("t3_in_ready", 32'(in_ready), (i < 16) ? 32'd1 : 32'd0);
      check_eq("t3_no_early_overflow", 32'(overflow), 32'd0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    #1;
    check_eq("t3_overflow", 32'(overflow), 32'd1);
    check_eq("t3_busy", 32'(busy), 32'd0);
    check_eq("t3_out_valid", 32'(out_valid), 32'd0);
    check_eq("t3_done", 32'(done), 32'd0);
    @(negedge clk);
    #1;
    check_eq("t3_done_after", 32'(done), 32'd0);
    check_eq("t3_overflow_sticky", 32'(overflow), 32'd1);

    // Illegal sizes: F=0, F>16, F>N.
    do_start(8'd4, 8'd0);
    check_eq("t4_f0_size_err", 32'(size_err), 32'd1);
    check_eq("t4_f0_busy", 32'(busy), 32'd0);
    check_eq("t4_overflow_cleared", 32'(overflow), 32'd0);
    @(negedge clk);
    #1;
    check_eq("t4_f0_still_idle", 32'(busy), 32'd0);
    do_start(8'd20, 8'd17);
    check_eq("t4_f17_size_err", 32'(size_err), 32'd1);
    check_eq("t4_f17_busy", 32'(busy), 32'd0);
    do_start(8'd3, 8'd4);
    check_eq("t4_fgtn_size_err", 32'(size_err), 32'd1);
    check_eq("t4_fgtn_busy", 32'(busy), 32'd0);
    check_eq("t4_fgtn_in_ready", 32'(in_ready), 32'd0);

    // N=3,F=3 -> single word; a start while streaming must not change the geometry.
    vec[0] = 32'hCAFE_0001;
    do_start(8'd3, 8'd3);
    check_eq("t5_size_err_cleared", 32'(size_err), 32'd0);
    check_eq("t5_busy", 32'(busy), 32'd1);
    do_start(8'd8, 8'd1);
    check_eq("t5_ignored_start_busy", 32'(busy), 32'd1);
    check_eq("t5_ignored_start_size_err", 32'(size_err), 32'd0);
    stream_frame("t5", 1, 1, 0, 0, 1'b0, -1);

    // N=8,F=3 -> D=6; reset (with a competing start) after 10 words, then a full 36-word frame.
    for (int i = 0; i < 36; i++) vec[i] = 32'hA500_0000 + 32'(i * 7);
    do_start(8'd8, 8'd3);
    stream_frame("t6a", 6, 36, 0, 0, 1'b0, 10);
    rst = 1'b1;
    start = 1'b1; input_size = 8'd8; filter_size = 8'd3;
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    check_reset_outputs("t6_rst");
    @(negedge clk);
    do_start(8'd8, 8'd3);
    check_eq("t6_restart_busy", 32'(busy), 32'd1);
    stream_frame("t6b", 6, 36, 0, 0, 1'b0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/conv_result_streamer.md
CONV_RESULT_STREAMER -- requirements
Module: conv_result_streamer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, result FIFO depth in words (power of two, >=2).
REQ-002 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  one-cycle frame start request.
REQ-005 SHALL have port input_size  input  8  input matrix edge length N, sampled on accepted start.
REQ-006 SHALL have port filter_size  input  8  filter edge length F, sampled on accepted start.
REQ-007 SHALL have port in_valid  input  1  result word present from convolution engine.
REQ-008 SHALL have port in_data  input  32  IEEE-754 single result word, raster order.
REQ-009 SHALL have port in_ready  output  1  FIFO not full and state STREAM.
REQ-010 SHALL have port out_valid  output  1  out_data holds a valid result word.
REQ-011 SHALL have port out_data  output  32  FIFO head word.
REQ-012 SHALL have port out_ready  input  1  downstream accepts word.
REQ-013 SHALL have port out_last_col  output  1  current out word is last of its row.
REQ-014 SHALL have port out_last  output  1  current out word is last of frame.
REQ-015 SHALL have port busy  output  1  high in STREAM.
REQ-016 SHALL have port done  output  1  one-cycle pulse after last word transferred.
REQ-017 SHALL have port size_err  output  1  sticky: last start had illegal sizes.
REQ-018 SHALL have port overflow  output  1  sticky: frame aborted on FIFO overflow.

Function
REQ-019 SHALL implement states IDLE, STREAM, DONE.
REQ-020 SHALL accept start only in IDLE; start in STREAM/DONE ignored.
REQ-021 On accepted start, SHALL latch N, F, clear size_err, overflow, FIFO, counters.
REQ-022 Sizes legal iff 1<=F<=16 and F<=N; illegal -> size_err=1 next cycle, stay IDLE.
REQ-023 Legal start -> STREAM next cycle; output edge D=N-F+1 (8 bit), frame length D*D (16 bit).
REQ-024 Input transfer = in_valid & in_ready; SHALL write in_data to FIFO tail, increment received count.
REQ-025 Once received count = D*D, in_ready SHALL be 0; further in_valid words ignored, no error.
REQ-026 Full FIFO: write refused even if a read occurs same cycle; in_ready=0.
REQ-027 in_valid=1 while FIFO full in STREAM (not all words received) SHALL set overflow, flush FIFO, go IDLE, no done.
REQ-028 out_valid = FIFO non-empty in STREAM; out_data = head, combinational from storage.
REQ-029 Output transfer = out_valid & out_ready; pops head, advances col, wraps col at D-1 to 0 with row+1.
REQ-030 out_last_col = out_valid & col==D-1; out_last = out_valid & col==D-1 & row==D-1.
REQ-031 out_data/out_last SHALL hold stable while out_valid & !out_ready.
REQ-032 Simultaneous push and pop on non-full, non-empty FIFO SHALL keep occupancy constant.
REQ-033 Push into empty FIFO SHALL give out_valid next cycle (1-cycle in-to-out latency).
REQ-034 Transfer of out_last word SHALL move to DONE; DONE asserts done for one cycle, returns IDLE.
REQ-035 FIFO pointers wrap modulo FIFO_DEPTH; occupancy counter width log2(FIFO_DEPTH)+1.

Reset
REQ-036 rst=1 at clock edge SHALL force IDLE, empty FIFO, zero counters, mid-frame included.
REQ-037 Reset values: in_ready=0, out_valid=0, out_last_col=0, out_last=0, busy=0, done=0, size_err=0, overflow=0, out_data don't-care.
REQ-038 rst SHALL take priority over start and all transfers in the same cycle.

Verification
REQ-039 N=4,F=3, 4 words 0x3F800000..0x40800000, out_ready=1 -> D=2, words in order, out_last_col on words 2,4, out_last on word 4, done pulse one cycle after.
REQ-040 N=5,F=2, out_ready low 20 cycles, 16 words pushed -> in_ready drops after 16, FIFO stalls, no overflow; release -> all 16 delivered in order, done.
REQ-041 FIFO_DEPTH=16, N=10,F=1, out_ready=0, in_valid held 17 cycles -> overflow=1 on 17th, busy=0, no done.
REQ-042 start with F=0, then F=17, then N=3,F=4 -> size_err=1 each, busy stays 0; next legal start clears size_err.
REQ-043 N=8,F=3, rst pulsed after 10 words delivered -> all outputs at reset values next cycle; fresh start completes 36-word frame.
REQ-044 N=3,F=3 -> single word, out_last_col=out_last=1 on it; start in STREAM ignored, sizes unchanged.
